// File: rtl/logic_op_arb_pkg.sv
// Shared types for the logic-op arbiter: the opcode and FSM state encodings,
// plus the legal parameter ranges.
package logic_op_arb_pkg;

  localparam int MIN_REQ    = 2;
  localparam int MAX_REQ    = 16;
  localparam int MAX_DATA_W = 64;

  typedef enum logic [1:0] {
    OP_NOT = 2'd0,
    OP_AND = 2'd1,
    OP_OR  = 2'd2,
    OP_XOR = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/logic_op_arbiter_rr_arbiter.sv
// Combinational round-robin picker. The requester at i_ptr has the highest
// priority; the search then continues upward and wraps modulo N.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_grant_valid,
  output logic [IDX_W-1:0] o_grant_idx
);

  // Scan N candidates starting at the pointer and take the first active one.
  always_comb begin : p_scan
    int w_cand;
    w_cand        = 0;
    o_grant_valid = 1'b0;
    o_grant_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = (int'(i_ptr) + k) % N;
      if (!o_grant_valid && i_req[w_cand]) begin
        o_grant_valid = 1'b1;
        o_grant_idx   = IDX_W'(w_cand);
      end
    end
  end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin sharing of one registered NOT/AND/OR/XOR unit between
// NUM_REQ requesters, with a single ID-tagged response channel.
// Optional grant counter output stat_grants when LOGIC_OP_ARB_STATS_EN is defined.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | offering a grant to the round-robin winner; operands latched on handshake
// EXEC  | logic unit result captured into the response register
// RESP  | response presented, held until the consumer accepts it
module logic_op_arbiter
  import logic_op_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0][1:0]         req_op,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_a,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_b,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            rsp_valid,
  output logic [ID_W-1:0]                 rsp_id,
  output logic [DATA_W-1:0]               rsp_data,
  input  logic                            rsp_ready
`ifdef LOGIC_OP_ARB_STATS_EN
  ,
  output logic [31:0]                     stat_grants
`endif
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     r_id;
  op_e                 r_op;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [DATA_W-1:0]   r_rsp_data;

  logic                w_grant_valid;
  logic [ID_W-1:0]     w_grant_idx;
  logic [NUM_REQ-1:0]  w_req_ready;
  logic                w_handshake;
  logic                w_rsp_done;
  logic [DATA_W-1:0]   w_result;
  logic [ID_W-1:0]     w_next_ptr;

  function automatic logic [DATA_W-1:0] logic_op_eval(
    input op_e               op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [DATA_W-1:0] res;
    case (op)
      OP_NOT:  res = ~a;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      default: res = '0;
    endcase
    return res;
  endfunction

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_rr_arbiter (
    .i_req         (req_valid),
    .i_ptr         (r_rr_ptr),
    .o_grant_valid (w_grant_valid),
    .o_grant_idx   (w_grant_idx)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, accept strobe and response-complete decode.
  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = '0;
    w_handshake = 1'b0;
    w_rsp_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_valid) begin
          w_req_ready[w_grant_idx] = 1'b1;
          w_handshake              = 1'b1;
          w_state_nxt              = EXEC;
        end
      end
      EXEC: begin
        w_state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          w_rsp_done  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Capture the winner's operands and ID on the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id <= '0;
      r_op <= OP_NOT;
      r_a  <= '0;
      r_b  <= '0;
    end else if (w_handshake) begin
      r_id <= w_grant_idx;
      r_op <= op_e'(req_op[w_grant_idx]);
      r_a  <= req_a[w_grant_idx];
      r_b  <= req_b[w_grant_idx];
    end
  end

  assign w_result = logic_op_eval(r_op, r_a, r_b);

  // Register the logic unit output; it stays frozen through RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_data <= '0;
    end else if (r_state == EXEC) begin
      r_rsp_data <= w_result;
    end
  end

  // The pointer moves past the served requester only once its response is taken.
  assign w_next_ptr = (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;

  // Round-robin pointer update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_rsp_done) begin
      r_rr_ptr <= w_next_ptr;
    end
  end

`ifdef LOGIC_OP_ARB_STATS_EN
  logic [31:0] r_stat_grants;

  // Free-running count of accepted requests; wraps naturally at 32 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_grants <= '0;
    end else if (w_handshake) begin
      r_stat_grants <= r_stat_grants + 32'd1;
    end
  end

  assign stat_grants = r_stat_grants;
`endif

  assign req_ready = w_req_ready;
  assign rsp_valid = (r_state == RESP);
  assign rsp_id    = r_id;
  assign rsp_data  = r_rsp_data;

endmodule
